// File: rtl/irst_reg_tx.sv
// Register-file dump transmitter: streams R0..R7 toward the core over a valid/ready handshake.
// Build option: define IRST_CSUM_EN to append a 16-bit XOR checksum word to every dump.
//
//   state | meaning
//   IDLE  | waiting for start; reg_rd_addr parked at 0
//   FETCH | read register idx into the output word register
//   SEND  | hold word idx valid until the core accepts it
//   CSUM  | present the XOR checksum as a final word (IRST_CSUM_EN only)
//   DONE  | one-cycle irst_done pulse, then back to IDLE
module irst_reg_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [2:0]  reg_rd_addr,
    input  logic [15:0] reg_rd_data,
    output logic [15:0] irst_reg_data,
    output logic        irst_valid,
    input  logic        irst_ready,
    output logic        irst_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
`ifdef IRST_CSUM_EN
        , CSUM
`endif
    } state_t;

    state_t      state_q;
    logic [2:0]  idx_q;
    logic [15:0] data_q;
    logic        valid_q;
    logic        done_q;
    logic        busy_q;
`ifdef IRST_CSUM_EN
    logic [15:0] csum_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            data_q  <= 16'h0000;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef IRST_CSUM_EN
            csum_q  <= 16'h0000;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q   <= 3'd0;
                        state_q <= FETCH;
                        busy_q  <= 1'b1;
`ifdef IRST_CSUM_EN
                        csum_q  <= 16'h0000;
`endif
                    end
                end
                FETCH: begin
                    data_q  <= reg_rd_data;
                    valid_q <= 1'b1;
                    state_q <= SEND;
`ifdef IRST_CSUM_EN
                    csum_q  <= csum_q ^ reg_rd_data;
`endif
                end
                SEND: begin
                    if (valid_q && irst_ready) begin
                        valid_q <= 1'b0;
                        if (idx_q != 3'd7) begin
                            idx_q   <= idx_q + 3'd1;
                            state_q <= FETCH;
                        end else begin
`ifdef IRST_CSUM_EN
                            state_q <= CSUM;
`else
                            state_q <= DONE;
                            done_q  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef IRST_CSUM_EN
                // First CSUM cycle loads the word, keeping the two-cycle word spacing.
                CSUM: begin
                    if (!valid_q) begin
                        data_q  <= csum_q;
                        valid_q <= 1'b1;
                    end else if (irst_ready) begin
                        valid_q <= 1'b0;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign reg_rd_addr   = (state_q == IDLE || state_q == DONE) ? 3'd0 : idx_q;
    assign irst_reg_data = data_q;
    assign irst_valid    = valid_q;
    assign irst_done     = done_q;
    assign busy          = busy_q;

endmodule
